instream_loader: RTL and testbench

- Configuration controller for the four-lane input-stream row.
- Receives a host word stream over a valid/ready handshake and writes per-stream lengths and 11-bit signed sample tables into registers that drive the row's length and data inputs.
- Gates execution through a run output: streams are held idle while loading and released on a RUN command.
- Sits between the host link deserializer and the input-stream row.

---
 rtl/instream_loader.sv | 189 ++++++++++++++++++
 tb/tb_instream_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instream_loader.sv
// instream_loader: configuration controller for the four-lane input-stream row.
// A host word stream loads per-lane sample tables and lengths, then a RUN
// command releases the streams until a STOP returns control to the host.
module instream_loader #(
    parameter int N_STREAMS = 4,
    parameter int DEPTH     = 64,
    parameter int DATA_W    = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(DEPTH)-1:0]   length [0:N_STREAMS-1],
    output logic [DATA_W-1:0]          data   [0:N_STREAMS*DEPTH-1],
    output logic                       run,
    output logic                       busy,
    output logic                       err
);

    localparam int LANE_W = $clog2(N_STREAMS);
    localparam int CNT_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STOP = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    state_t             state, state_nxt;
    logic [LANE_W-1:0]  lane_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    op_t                op;
    logic [LANE_W-1:0]  cmd_lane;
    logic [CNT_W-1:0]   cmd_len;
    logic               last_word;

    // Decode strobes, valid only on the cycle a word is accepted
    logic               do_load_start;
    logic               do_load_clear;
    logic               do_run;
    logic               do_stop;
    logic               do_err;
    logic               do_write;
    logic               do_done;

    // Bit 11 of the host word carries nothing in either command or data form
    logic               unused_bits;

    assign accept      = in_valid && in_ready;
    assign op          = op_t'(in_data[15:14]);
    assign cmd_lane    = in_data[12 +: LANE_W];
    assign cmd_len     = in_data[CNT_W-1:0];
    assign last_word   = (cnt_q == (len_q - CNT_ONE));
    assign unused_bits = in_data[11];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-word action decode
    always_comb begin
        state_nxt     = state;
        do_load_start = 1'b0;
        do_load_clear = 1'b0;
        do_run        = 1'b0;
        do_stop       = 1'b0;
        do_err        = 1'b0;
        do_write      = 1'b0;
        do_done       = 1'b0;
        if (accept) begin
            unique case (state)
                S_IDLE: begin
                    unique case (op)
                        OP_LOAD: begin
                            do_load_clear = 1'b1;
                            if (cmd_len != '0) begin
                                do_load_start = 1'b1;
                                state_nxt     = S_LOAD;
                            end
                        end
                        OP_RUN: begin
                            do_run    = 1'b1;
                            state_nxt = S_RUN;
                        end
                        OP_STOP: ;
                        OP_RSVD: do_err = 1'b1;
                    endcase
                end
                S_LOAD: begin
                    do_write = 1'b1;
                    if (last_word) begin
                        do_done   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (op == OP_STOP) begin
                        do_stop   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        do_err = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Control registers: handshake, load bookkeeping and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            lane_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            run      <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            if (do_load_start) begin
                lane_q <= cmd_lane;
                len_q  <= cmd_len;
                cnt_q  <= '0;
                busy   <= 1'b1;
            end
            if (do_write) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (do_done) begin
                busy <= 1'b0;
            end
            if (do_run) begin
                run <= 1'b1;
            end
            if (do_stop) begin
                run <= 1'b0;
            end
            if (do_err) begin
                err <= 1'b1;
            end
        end
    end

    // Length table: held at zero for the whole load so a partial table is never exposed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_STREAMS; i++) begin
                length[i] <= '0;
            end
        end else begin
            if (do_load_clear) begin
                length[cmd_lane] <= '0;
            end
            if (do_done) begin
                length[lane_q] <= len_q;
            end
        end
    end

    // Sample table: lane and slot counter concatenate into the flat table index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_STREAMS*DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (do_write) begin
            data[{lane_q, cnt_q}] <= in_data[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_instream_loader.sv
// Directed bench for instream_loader: stimulus pushes expected observations
// into a queue, a monitor on the falling edge pops and compares them.
module tb_instream_loader;

    localparam int K_LEN   = 0;
    localparam int K_DATA  = 1;
    localparam int K_RUN   = 2;
    localparam int K_BUSY  = 3;
    localparam int K_ERR   = 4;
    localparam int K_READY = 5;

    typedef struct {
        int    kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  length [0:3];
    logic [10:0] data   [0:255];
    logic        run;
    logic        busy;
    logic        err;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic [10:0] lane3_vals [0:62];

    instream_loader #(
        .N_STREAMS(4),
        .DEPTH(64),
        .DATA_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .length(length),
        .data(data),
        .run(run),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void expect_val(int kind, int idx, int val, string name);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        expq.push_back(e);
    endfunction

    // Monitor: drains every pending expectation against the settled outputs
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                case (e.kind)
                    K_LEN:   act = int'(length[e.idx]);
                    K_DATA:  act = int'(data[e.idx]);
                    K_RUN:   act = int'(run);
                    K_BUSY:  act = int'(busy);
                    K_ERR:   act = int'(err);
                    default: act = int'(in_ready);
                endcase
                checks++;
                if (act != e.val) begin
                    errors++;
                    $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t",
                             e.name, e.idx, act, e.val, $time);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word; returns 1 ns after the accepting edge
    task automatic send(input logic [15:0] w, input bit keep);
        int waited;
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic expect_idle_status(input int r, input int b, input int e);
        expect_val(K_RUN,  0, r, "run");
        expect_val(K_BUSY, 0, b, "busy");
        expect_val(K_ERR,  0, e, "err");
    endtask

    initial begin
        int t;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;

        // Reset values
        expect_idle_status(0, 0, 0);
        expect_val(K_READY, 0, 0, "in_ready");
        expect_val(K_LEN, 1, 0, "length");
        expect_val(K_DATA, 64, 0, "data");
        idle(2);
        rst = 1'b1;
        idle(1);
        expect_val(K_READY, 0, 1, "in_ready");
        idle(1);

        // LOAD lane 1 len 3 with back-to-back words
        send(16'h1003, 1'b1);
        expect_val(K_BUSY, 0, 1, "busy"); expect_val(K_LEN, 1, 0, "length");
        send(16'h0005, 1'b1);
        expect_val(K_BUSY, 0, 1, "busy"); expect_val(K_LEN, 1, 0, "length");
        send(16'h07FF, 1'b1);
        expect_val(K_BUSY, 0, 1, "busy"); expect_val(K_LEN, 1, 0, "length");
        send(16'h0400, 1'b0);
        expect_val(K_BUSY, 0, 0, "busy"); expect_val(K_LEN, 1, 3, "length");
        expect_val(K_DATA, 64, 16'h005, "data");
        expect_val(K_DATA, 65, 16'h7FF, "data");
        expect_val(K_DATA, 66, 16'h400, "data");
        idle(1);

        // LOAD lane 3 len 63 with random stalls between words
        for (int i = 0; i < 63; i++) lane3_vals[i] = 11'((i * 37 + 3) & 'h7FF);
        send(16'h303F, 1'b0);
        for (int i = 0; i < 63; i++) begin
            idle($urandom_range(0, 3));
            if (i == 62) expect_val(K_LEN, 3, 0, "length");
            send({5'b0, lane3_vals[i]}, 1'b0);
        end
        expect_val(K_LEN, 3, 63, "length");
        expect_val(K_BUSY, 0, 0, "busy");
        for (int i = 0; i < 63; i += 9) expect_val(K_DATA, 192 + i, int'(lane3_vals[i]), "data");
        expect_val(K_DATA, 254, int'(lane3_vals[62]), "data");
        expect_val(K_DATA, 255, 0, "data");
        idle(1);

        // LOAD lane 0 len 2 (upper data bits ignored), then RUN / bad word / STOP
        send(16'h0002, 1'b1);
        send(16'h0123, 1'b1);
        send(16'hF801, 1'b0);
        expect_val(K_LEN, 0, 2, "length");
        expect_val(K_DATA, 0, 16'h123, "data");
        expect_val(K_DATA, 1, 16'h001, "data");
        idle(1);
        send(16'h4000, 1'b0);
        expect_idle_status(1, 0, 0);
        idle(1);
        send(16'h0001, 1'b0);
        expect_idle_status(1, 0, 1);
        expect_val(K_LEN, 0, 2, "length");
        idle(1);
        send(16'h8000, 1'b0);
        expect_idle_status(0, 0, 1);
        expect_val(K_LEN, 0, 2, "length");
        expect_val(K_LEN, 1, 3, "length");
        expect_val(K_DATA, 65, 16'h7FF, "data");
        idle(1);

        // Asynchronous reset after 2 of 5 data words
        send(16'h2005, 1'b0);
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        expect_val(K_BUSY, 0, 1, "busy");
        idle(1);
        #2;
        rst = 1'b0;
        expect_idle_status(0, 0, 0);
        expect_val(K_READY, 0, 0, "in_ready");
        expect_val(K_LEN, 2, 0, "length");
        expect_val(K_LEN, 1, 0, "length");
        expect_val(K_DATA, 128, 0, "data");
        expect_val(K_DATA, 64, 0, "data");
        idle(2);
        #3;
        rst = 1'b1;
        idle(1);
        expect_val(K_READY, 0, 1, "in_ready");
        idle(1);
        send(16'h2002, 1'b1);
        send(16'h00AA, 1'b1);
        send(16'h0555, 1'b0);
        expect_val(K_LEN, 2, 2, "length");
        expect_val(K_DATA, 128, 16'h0AA, "data");
        expect_val(K_DATA, 129, 16'h555, "data");
        expect_idle_status(0, 0, 0);
        idle(1);

        // Reserved word in IDLE, then zero-length LOAD
        send(16'hC000, 1'b0);
        expect_idle_status(0, 0, 1);
        expect_val(K_LEN, 2, 2, "length");
        idle(1);
        send(16'h2000, 1'b0);
        expect_val(K_LEN, 2, 0, "length");
        expect_val(K_BUSY, 0, 0, "busy");
        expect_val(K_DATA, 128, 16'h0AA, "data");
        idle(1);
        // A following word in IDLE must decode as a command, not data
        send(16'h4000, 1'b0);
        expect_val(K_RUN, 0, 1, "run");
        expect_val(K_DATA, 130, 0, "data");

        t = 0;
        while (expq.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending got %0d expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
